// File: rtl/ahb_pkg.sv
// Shared AHB slave types: transfer encoding, register offsets and controller states.
// ERR1/ERR2 states exist only when AHB_SLAVE_ERR_RESP_EN is defined.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_t;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;

    localparam logic [7:0] OFF_PAYLOAD_0 = 8'h00;
    localparam logic [7:0] OFF_PAYLOAD_1 = 8'h01;
    localparam logic [7:0] OFF_DATA_SIZE = 8'h02;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
`ifdef AHB_SLAVE_ERR_RESP_EN
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4,
`endif
        ST_DATA = 3'd2
    } slv_state_t;

endpackage

// File: rtl/ahb_wait_counter.sv
// 3-bit loadable down-counter; done is high while the count is zero.
module ahb_wait_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [2:0] load_val,
    input  logic       dec,
    output logic       done
);

    logic [2:0] count_reg;

    // Saturates at zero so a stray decrement cannot wrap into a long stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= 3'd0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (dec && (count_reg != 3'd0)) begin
            count_reg <= count_reg - 3'd1;
        end
    end

    assign done = (count_reg == 3'd0);

endmodule

// File: rtl/ahb_slave_ctrl.sv
// AHB-Lite slave control: address-phase capture, offset decode, wait states and strobes.
// Define AHB_SLAVE_ERR_RESP_EN to answer illegal transfers with a two-cycle ERROR response.
module ahb_slave_ctrl
    import ahb_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              hclk,
    input  logic              hreset,
    input  logic              hsel_x,
    input  logic [ADDR_W-1:0] haddr,
    input  logic              hwrite,
    input  logic [1:0]        htrans,
    input  logic [2:0]        hsize,
    input  logic              hready,
    output logic              hreadyout,
    output logic              hresp,
    output logic [1:0]        write_select,
    output logic              wr_en,
    output logic              rd_en
);

    localparam logic [2:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;

    slv_state_t state_reg, state_next;
    logic [1:0] sel_reg, sel_next;
    logic       write_reg, write_next;
    logic       legal_reg, legal_next;
    logic       hreadyout_reg, hreadyout_next;
    logic       wr_en_reg, wr_en_next;
    logic       rd_en_reg, rd_en_next;
    logic [1:0] write_select_reg, write_select_next;

    htrans_t    trans;
    logic       accept;
    logic       mapped;
    logic [1:0] index_in;
    logic       legal_in;
    logic       wait_load;
    logic       wait_done;

    assign trans  = htrans_t'(htrans);
    assign accept = hsel_x && hready && ((trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ));

    always_comb begin
        mapped   = 1'b1;
        index_in = 2'd0;
        if (haddr == ADDR_W'(OFF_PAYLOAD_0)) begin
            index_in = 2'd0;
        end else if (haddr == ADDR_W'(OFF_PAYLOAD_1)) begin
            index_in = 2'd1;
        end else if (haddr == ADDR_W'(OFF_DATA_SIZE)) begin
            index_in = 2'd2;
        end else begin
            mapped = 1'b0;
        end
    end

    assign legal_in = mapped && (hsize == HSIZE_BYTE);

    ahb_wait_counter u_wait_counter (
        .clk      (hclk),
        .rst      (hreset),
        .load     (wait_load),
        .load_val (WAIT_LOAD),
        .dec      (state_reg == ST_WAIT),
        .done     (wait_done)
    );

    always_comb begin
        state_next = state_reg;
        sel_next   = sel_reg;
        write_next = write_reg;
        legal_next = legal_reg;
        wait_load  = 1'b0;
        case (state_reg)
            ST_WAIT: begin
                if (wait_done) state_next = ST_DATA;
            end
`ifdef AHB_SLAVE_ERR_RESP_EN
            ST_ERR1: begin
                state_next = ST_ERR2;
            end
`endif
            // IDLE, DATA and ERR2 all take a new address phase the same way.
            default: begin
                state_next = ST_IDLE;
                if (accept) begin
                    sel_next   = index_in;
                    write_next = hwrite;
                    legal_next = legal_in;
`ifdef AHB_SLAVE_ERR_RESP_EN
                    if (!legal_in) begin
                        state_next = ST_ERR1;
                    end else
`endif
                    if (WAIT_CYCLES > 0) begin
                        state_next = ST_WAIT;
                        wait_load  = 1'b1;
                    end else begin
                        state_next = ST_DATA;
                    end
                end
            end
        endcase
    end

    // Outputs are decoded from the next state so they leave straight from flops.
    always_comb begin
        hreadyout_next    = 1'b1;
        wr_en_next        = 1'b0;
        rd_en_next        = 1'b0;
        write_select_next = 2'd0;
        case (state_next)
            ST_WAIT: hreadyout_next = 1'b0;
            ST_DATA: begin
                wr_en_next        = legal_next && write_next;
                rd_en_next        = legal_next && !write_next;
                write_select_next = legal_next ? sel_next : 2'd0;
            end
`ifdef AHB_SLAVE_ERR_RESP_EN
            ST_ERR1: hreadyout_next = 1'b0;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_reg        <= ST_IDLE;
            sel_reg          <= 2'd0;
            write_reg        <= 1'b0;
            legal_reg        <= 1'b0;
            hreadyout_reg    <= 1'b1;
            wr_en_reg        <= 1'b0;
            rd_en_reg        <= 1'b0;
            write_select_reg <= 2'd0;
        end else begin
            state_reg        <= state_next;
            sel_reg          <= sel_next;
            write_reg        <= write_next;
            legal_reg        <= legal_next;
            hreadyout_reg    <= hreadyout_next;
            wr_en_reg        <= wr_en_next;
            rd_en_reg        <= rd_en_next;
            write_select_reg <= write_select_next;
        end
    end

`ifdef AHB_SLAVE_ERR_RESP_EN
    logic hresp_reg;

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            hresp_reg <= 1'b0;
        end else begin
            hresp_reg <= (state_next == ST_ERR1) || (state_next == ST_ERR2);
        end
    end

    assign hresp = hresp_reg;
`else
    assign hresp = 1'b0;
`endif

    assign hreadyout    = hreadyout_reg;
    assign wr_en        = wr_en_reg;
    assign rd_en        = rd_en_reg;
    assign write_select = write_select_reg;

endmodule

// File: tb/tb_ahb_slave_ctrl.sv
// Self-checking bench for ahb_slave_ctrl: three instances (0, 2 and 3 wait states) on shared bus inputs.
module tb_ahb_slave_ctrl;

    localparam int NDUT = 3;
    localparam int RMAX = 400;
`ifdef AHB_SLAVE_ERR_RESP_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic            hclk = 1'b0;
    logic            hreset;
    logic [NDUT-1:0] hsel_x;
    logic [7:0]      haddr;
    logic            hwrite;
    logic [1:0]      htrans;
    logic [2:0]      hsize;
    logic            hready;
    logic [NDUT-1:0] hreadyout;
    logic [NDUT-1:0] hresp;
    logic [NDUT-1:0] wr_en;
    logic [NDUT-1:0] rd_en;
    logic [1:0]      write_select [NDUT];

    int checks = 0;
    int errors = 0;

    always #5 hclk = ~hclk;

    generate
        for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
            ahb_slave_ctrl #(
                .ADDR_W      (8),
                .WAIT_CYCLES ((gi == 0) ? 0 : gi + 1)
            ) u_dut (
                .hclk         (hclk),
                .hreset       (hreset),
                .hsel_x       (hsel_x[gi]),
                .haddr        (haddr),
                .hwrite       (hwrite),
                .htrans       (htrans),
                .hsize        (hsize),
                .hready       (hready),
                .hreadyout    (hreadyout[gi]),
                .hresp        (hresp[gi]),
                .write_select (write_select[gi]),
                .wr_en        (wr_en[gi]),
                .rd_en        (rd_en[gi])
            );
        end
    endgenerate

    function automatic int wait_of(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 2 : 3);
    endfunction

    task automatic drive_idle();
        hsel_x = '0;
        htrans = 2'd0;
        haddr  = 8'h00;
        hwrite = 1'b0;
        hsize  = 3'd0;
        hready = 1'b1;
    endtask

    task automatic drive_xfer(input int d, input logic [7:0] a, input logic w, input logic [2:0] sz);
        hsel_x    = '0;
        hsel_x[d] = 1'b1;
        htrans    = 2'd2;
        haddr     = a;
        hwrite    = w;
        hsize     = sz;
        hready    = 1'b1;
        $display("xfer dut%0d addr %h %s size %0d", d, a, w ? "write" : "read", sz);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge hclk);
        @(negedge hclk);
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if ({hreadyout[d], hresp[d], wr_en[d], rd_en[d], write_select[d]} !== 6'b100000) begin
                errors++;
                $display("FAIL reset_state dut%0d rdy/resp/wr/rd/sel got %b want 100000", d,
                         {hreadyout[d], hresp[d], wr_en[d], rd_en[d], write_select[d]});
            end
        end
        hreset = 1'b0;
    endtask

    task automatic test_write_w0();
        @(negedge hclk);
        drive_xfer(0, 8'h01, 1'b1, 3'd0);
        @(negedge hclk);
        checks++;
        if ({hreadyout[0], hresp[0], wr_en[0], rd_en[0], write_select[0]} !== 6'b101001) begin
            errors++;
            $display("FAIL write_w0_data rdy/resp/wr/rd/sel got %b want 101001",
                     {hreadyout[0], hresp[0], wr_en[0], rd_en[0], write_select[0]});
        end
        drive_idle();
        @(negedge hclk);
        checks++;
        if ({hreadyout[0], hresp[0], wr_en[0], rd_en[0], write_select[0]} !== 6'b100000) begin
            errors++;
            $display("FAIL write_w0_after rdy/resp/wr/rd/sel got %b want 100000",
                     {hreadyout[0], hresp[0], wr_en[0], rd_en[0], write_select[0]});
        end
    endtask

    task automatic test_read_w2();
        logic [5:0] want [4];
        want[0] = 6'b000000;
        want[1] = 6'b000000;
        want[2] = 6'b100110;
        want[3] = 6'b100000;
        @(negedge hclk);
        drive_xfer(1, 8'h02, 1'b0, 3'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge hclk);
            checks++;
            if ({hreadyout[1], hresp[1], wr_en[1], rd_en[1], write_select[1]} !== want[i]) begin
                errors++;
                $display("FAIL read_w2_cyc%0d rdy/resp/wr/rd/sel got %b want %b", i + 1,
                         {hreadyout[1], hresp[1], wr_en[1], rd_en[1], write_select[1]}, want[i]);
            end
            drive_idle();
            // An unrelated slave's stall must not disturb the wait sequence.
            hready = (i == 1) ? 1'b1 : 1'b0;
        end
        hready = 1'b1;
    endtask

    task automatic test_back_to_back();
        @(negedge hclk);
        drive_xfer(0, 8'h00, 1'b1, 3'd0);
        @(negedge hclk);
        checks++;
        if ({hreadyout[0], hresp[0], wr_en[0], rd_en[0], write_select[0]} !== 6'b101000) begin
            errors++;
            $display("FAIL b2b_first rdy/resp/wr/rd/sel got %b want 101000",
                     {hreadyout[0], hresp[0], wr_en[0], rd_en[0], write_select[0]});
        end
        drive_xfer(0, 8'h02, 1'b1, 3'd0);
        @(negedge hclk);
        checks++;
        if ({hreadyout[0], hresp[0], wr_en[0], rd_en[0], write_select[0]} !== 6'b101010) begin
            errors++;
            $display("FAIL b2b_second rdy/resp/wr/rd/sel got %b want 101010",
                     {hreadyout[0], hresp[0], wr_en[0], rd_en[0], write_select[0]});
        end
        drive_idle();
        @(negedge hclk);
        checks++;
        if ({hreadyout[0], hresp[0], wr_en[0], rd_en[0], write_select[0]} !== 6'b100000) begin
            errors++;
            $display("FAIL b2b_after rdy/resp/wr/rd/sel got %b want 100000",
                     {hreadyout[0], hresp[0], wr_en[0], rd_en[0], write_select[0]});
        end
    endtask

    task automatic test_illegal();
        logic [3:0] want_a [3];
        logic [3:0] want_b [4];
        // Unmapped offset on the zero-wait instance.
        want_a[0] = ERR_EN ? 4'b0100 : 4'b1000;
        want_a[1] = ERR_EN ? 4'b1100 : 4'b1000;
        want_a[2] = 4'b1000;
        @(negedge hclk);
        drive_xfer(0, 8'h05, 1'b1, 3'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge hclk);
            checks++;
            if ({hreadyout[0], hresp[0], wr_en[0], rd_en[0]} !== want_a[i]) begin
                errors++;
                $display("FAIL illegal_addr_cyc%0d rdy/resp/wr/rd got %b want %b", i + 1,
                         {hreadyout[0], hresp[0], wr_en[0], rd_en[0]}, want_a[i]);
            end
            drive_idle();
        end
        // Halfword size to a mapped offset on the two-wait instance.
        want_b[0] = ERR_EN ? 4'b0100 : 4'b0000;
        want_b[1] = ERR_EN ? 4'b1100 : 4'b0000;
        want_b[2] = 4'b1000;
        want_b[3] = 4'b1000;
        @(negedge hclk);
        drive_xfer(1, 8'h00, 1'b1, 3'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge hclk);
            checks++;
            if ({hreadyout[1], hresp[1], wr_en[1], rd_en[1]} !== want_b[i]) begin
                errors++;
                $display("FAIL illegal_size_cyc%0d rdy/resp/wr/rd got %b want %b", i + 1,
                         {hreadyout[1], hresp[1], wr_en[1], rd_en[1]}, want_b[i]);
            end
            drive_idle();
        end
    endtask

    task automatic test_busy_idle();
        for (int i = 0; i < 6; i++) begin
            @(negedge hclk);
            if (i > 0) begin
                checks++;
                if ({hreadyout[0], hresp[0], wr_en[0], rd_en[0], write_select[0]} !== 6'b100000) begin
                    errors++;
                    $display("FAIL busy_idle_cyc%0d rdy/resp/wr/rd/sel got %b want 100000", i,
                             {hreadyout[0], hresp[0], wr_en[0], rd_en[0], write_select[0]});
                end
            end
            hsel_x    = '0;
            hsel_x[0] = 1'b1;
            haddr     = 8'h01;
            hwrite    = 1'b1;
            hsize     = 3'd0;
            // BUSY, IDLE, then NONSEQ while hready is low: none may be accepted.
            htrans    = (i < 2) ? 2'd1 : ((i < 4) ? 2'd0 : 2'd2);
            hready    = (i < 4) ? 1'b1 : 1'b0;
        end
        @(negedge hclk);
        checks++;
        if ({hreadyout[0], hresp[0], wr_en[0], rd_en[0], write_select[0]} !== 6'b100000) begin
            errors++;
            $display("FAIL busy_idle_last rdy/resp/wr/rd/sel got %b want 100000",
                     {hreadyout[0], hresp[0], wr_en[0], rd_en[0], write_select[0]});
        end
        drive_idle();
    endtask

    task automatic test_reset_mid_wait();
        @(negedge hclk);
        drive_xfer(2, 8'h01, 1'b1, 3'd0);
        @(negedge hclk);
        checks++;
        if (hreadyout[2] !== 1'b0) begin
            errors++;
            $display("FAIL rst_wait_entry hreadyout got %b want 0", hreadyout[2]);
        end
        drive_idle();
        #2 hreset = 1'b1;
        #1;
        checks++;
        if ({hreadyout[2], hresp[2], wr_en[2], rd_en[2], write_select[2]} !== 6'b100000) begin
            errors++;
            $display("FAIL rst_wait_async rdy/resp/wr/rd/sel got %b want 100000",
                     {hreadyout[2], hresp[2], wr_en[2], rd_en[2], write_select[2]});
        end
        @(negedge hclk);
        hreset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge hclk);
            checks++;
            if ({hreadyout[2], hresp[2], wr_en[2], rd_en[2], write_select[2]} !== 6'b100000) begin
                errors++;
                $display("FAIL rst_wait_after_cyc%0d rdy/resp/wr/rd/sel got %b want 100000", i,
                         {hreadyout[2], hresp[2], wr_en[2], rd_en[2], write_select[2]});
            end
        end
    endtask

    // Reference: each accepted transfer books its response into per-cycle expectation arrays.
    task automatic test_random(input int d, input int ncyc);
        bit         exp_rdy  [RMAX + 16];
        bit         exp_resp [RMAX + 16];
        bit         exp_wr   [RMAX + 16];
        bit         exp_rd   [RMAX + 16];
        bit   [1:0] exp_sel  [RMAX + 16];
        bit         sel_chk  [RMAX + 16];
        bit         busy     [RMAX + 16];
        int         w;
        logic       s;
        logic       wr;
        logic       rdy_d;
        logic       legal;
        logic [1:0] t;
        logic [7:0] a;
        logic [2:0] sz;
        w = wait_of(d);
        for (int i = 0; i < RMAX + 16; i++) begin
            exp_rdy[i]  = 1'b1;
            exp_resp[i] = 1'b0;
            exp_wr[i]   = 1'b0;
            exp_rd[i]   = 1'b0;
            exp_sel[i]  = 2'd0;
            sel_chk[i]  = 1'b1;
            busy[i]     = 1'b0;
        end
        for (int c = 0; c < ncyc + 10; c++) begin
            @(negedge hclk);
            checks++;
            if ({hreadyout[d], hresp[d], wr_en[d], rd_en[d]} !== {exp_rdy[c], exp_resp[c], exp_wr[c], exp_rd[c]}) begin
                errors++;
                $display("FAIL rand_dut%0d_cyc%0d rdy/resp/wr/rd got %b want %b", d, c,
                         {hreadyout[d], hresp[d], wr_en[d], rd_en[d]},
                         {exp_rdy[c], exp_resp[c], exp_wr[c], exp_rd[c]});
            end
            if (sel_chk[c]) begin
                checks++;
                if (write_select[d] !== exp_sel[c]) begin
                    errors++;
                    $display("FAIL rand_sel_dut%0d_cyc%0d write_select got %0d want %0d", d, c,
                             write_select[d], exp_sel[c]);
                end
            end
            s     = (c < ncyc) && ($urandom_range(3) != 0);
            t     = 2'($urandom_range(3));
            a     = ($urandom_range(4) == 0) ? 8'($urandom) : 8'($urandom_range(2));
            wr    = 1'($urandom_range(1));
            sz    = ($urandom_range(9) == 0) ? 3'($urandom_range(7, 1)) : 3'd0;
            rdy_d = busy[c] ? exp_rdy[c] : ($urandom_range(4) != 0);
            hsel_x    = '0;
            hsel_x[d] = s;
            htrans    = t;
            haddr     = a;
            hwrite    = wr;
            hsize     = sz;
            hready    = rdy_d;
            if (s && rdy_d && t[1]) begin
                legal = (a < 8'd3) && (sz == 3'd0);
                $display("xfer dut%0d cyc %0d addr %h %s size %0d %s", d, c, a,
                         wr ? "write" : "read", sz, legal ? "legal" : "illegal");
                if (legal || !ERR_EN) begin
                    for (int k = 1; k <= w; k++) begin
                        exp_rdy[c + k] = 1'b0;
                        busy[c + k]    = 1'b1;
                    end
                    busy[c + w + 1]    = 1'b1;
                    exp_wr[c + w + 1]  = legal && wr;
                    exp_rd[c + w + 1]  = legal && !wr;
                    exp_sel[c + w + 1] = legal ? a[1:0] : 2'd0;
                    sel_chk[c + w + 1] = legal;
                end else begin
                    exp_rdy[c + 1]  = 1'b0;
                    exp_resp[c + 1] = 1'b1;
                    exp_resp[c + 2] = 1'b1;
                    busy[c + 1]     = 1'b1;
                    busy[c + 2]     = 1'b1;
                end
            end
        end
        drive_idle();
    endtask

    initial begin
        hreset = 1'b1;
        drive_idle();
        test_reset();
        test_write_w0();
        test_read_w2();
        test_back_to_back();
        test_illegal();
        test_busy_idle();
        test_reset_mid_wait();
        for (int d = 0; d < NDUT; d++) begin
            test_random(d, 300);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ahb_slave_ctrl.md
# ahb_slave_ctrl

AHB-Lite slave control stage that sits directly upstream of the payload/size register block. It samples the address phase, decodes the register offset, and inserts the configured wait states. In the data phase it drives the `write_select`/`wr_en` strobes consumed by the register block, along with the slave-side `hreadyout`/`hresp` response.

## Interface
- `ADDR_W`, 8: width of `haddr`.
- `WAIT_CYCLES`, 0: wait states inserted per legal transfer; legal range 0..7.
- `hclk`  in  1  bus clock; all logic on rising edge.
- `hreset`  in  1  reset, asynchronous, active-high.
- `hsel_x`  in  1  slave select from the address decoder.
- `haddr`  in  ADDR_W  address-phase address.
- `hwrite`  in  1  address-phase direction; 1 = write.
- `htrans`  in  2  transfer type: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- `hsize`  in  3  transfer size; only 0 (byte) is legal.
- `hready`  in  1  global bus ready (mux of all slaves' `hreadyout`).
- `hreadyout`  out  1  this slave's ready.
- `hresp`  out  1  0 = OKAY, 1 = ERROR.
- `write_select`  out  2  register index for the register block.
- `wr_en`  out  1  write strobe; feeds the register block's `hwrite`.
- `rd_en`  out  1  read strobe; `write_select` qualifies it.

## Operation
- **Address phase accepted** when `hsel_x && hready && htrans[1]`.
  - BUSY and IDLE are never accepted.
  - On acceptance, latch offset, `hwrite` and legality.
- **Register map** (offset = `haddr`):
  - 0x00 → `payload_0`, select 0.
  - 0x01 → `payload_1`, select 1.
  - 0x02 → `data_size`, select 2.
  - All other offsets are unmapped.
- **Illegal transfer**: unmapped offset, or `hsize != 0`.
- **FSM states**: IDLE, WAIT, DATA, ERR1, ERR2.
  - IDLE → WAIT on a legal accept when `WAIT_CYCLES > 0`; otherwise IDLE → DATA.
  - IDLE → ERR1 on an illegal accept.
  - WAIT: down-counter loads `WAIT_CYCLES-1` on entry; exit to DATA when the count is 0.
  - DATA: go to WAIT, DATA or ERR1 if a new transfer is accepted in the same cycle (pipelined back-to-back); otherwise go to IDLE.
  - ERR1 → ERR2 unconditionally.
  - ERR2: accepts a new address phase exactly like IDLE and DATA do.
- **Strobes**:
  - `wr_en` is 1 only in DATA when the latched `hwrite` is 1.
  - `rd_en` is 1 only in DATA when the latched `hwrite` is 0.
  - `write_select` holds the latched index; it is 0 outside DATA.
- **Outputs per state**:
  - IDLE: `hreadyout`=1, `hresp`=0.
  - WAIT: `hreadyout`=0, `hresp`=0.
  - DATA: `hreadyout`=1, `hresp`=0.
  - ERR1: `hreadyout`=0, `hresp`=1.
  - ERR2: `hreadyout`=1, `hresp`=1.
- **Reset values** (async, immediate, including mid-transfer):
  - Outputs: `hreadyout`=1, `hresp`=0, `wr_en`=0, `rd_en`=0, `write_select`=0.
  - State IDLE, counter 0.
  - Any pending strobe is dropped.

## Timing
- Address phase sampled at edge N.
- With `WAIT_CYCLES`=W:
  - `hreadyout` is low for cycles N+1..N+W.
  - DATA occupies cycle N+1+W; `wr_en`/`rd_en` are high for exactly that one cycle.
  - The register block captures `hwdata` on the edge that ends DATA.
- Error response: ERR1 at N+1, ERR2 at N+2. Two-cycle response, `hresp` high in both cycles.
- `hsel_x`, `haddr` and `htrans` changes while `hready`=0 are ignored.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- Macro: `AHB_SLAVE_ERR_RESP_EN`.
- **Defined**: illegal transfers take the ERR1/ERR2 path described above.
- **Undefined**:
  - Illegal transfers complete as OKAY with normal wait states.
  - `wr_en` and `rd_en` stay 0 for the transfer.
  - `hresp` is tied to 0.
  - ERR1 and ERR2 do not exist.

## Structure
- Package `ahb_pkg` holds:
  - `htrans_t` enum.
  - `HSIZE_BYTE` constant.
  - Register offset constants `OFF_PAYLOAD_0`, `OFF_PAYLOAD_1`, `OFF_DATA_SIZE`.
  - Controller state enum `slv_state_t`.
- Sub-module `ahb_wait_counter`: 3-bit loadable down-counter with a `done` flag, instantiated once.

## Test plan
- W=0, NONSEQ write to 0x01 → at N+1: `wr_en`=1, `write_select`=1, `hreadyout`=1, `hresp`=0.
- W=2, read to 0x02 → `hreadyout`=0 at N+1 and N+2; `rd_en`=1 and `write_select`=2 at N+3.
- Back-to-back NONSEQ writes to 0x00 then 0x02, W=0 → `wr_en` high two consecutive cycles; `write_select` goes 0 then 2.
- Write to 0x05, or `hsize`=1, with macro defined → `hreadyout`/`hresp` = 0/1 then 1/1; `wr_en` stays 0. Without the macro → OKAY and no strobe.
- BUSY or IDLE with `hsel_x`=1 → no state change; `hreadyout` stays 1.
- `hreset` asserted during WAIT (W=3) → `hreadyout`=1 and state IDLE immediately; no strobe appears after release.
